mux_rr: RTL
===========

# mux_rr

Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshake, registered output and two selection modes: externally directed (`sel`) or round-robin. It generalises the team's 4:1 combinational mux into a streaming merge stage. It sits between several producer channels and a single consumer, for example when merging sensor or UART byte streams onto one bus.

## Interface
Parameters:
- `WIDTH`, 4: data bits per channel
- `CHANNELS`, 4: number of input channels, ≥2, need not be a power of two
- `SELW`, `$clog2(CHANNELS)`: width of channel index; derived, not overridden

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = directed by `sel`, 1 = round-robin
- `sel`  in  SELW  channel index used when `mode`=0
- `in`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- `in_valid`  in  CHANNELS  per-channel data valid
- `in_ready`  out  CHANNELS  per-channel accept; at most one bit high
- `q`  out  WIDTH  registered output data
- `q_valid`  out  1  `q` holds an untaken item
- `q_chan`  out  SELW  source channel of `q`
- `q_ready`  in  1  consumer accepts `q`

## Operation
- The output register has two states: EMPTY (`q_valid`=0) and FULL (`q_valid`=1).
- Load enable: `load = !q_valid | q_ready`.
- Grant, combinational:
  - `mode`=0: grant channel `sel` only if `sel` < CHANNELS and `in_valid[sel]`. Otherwise there is no grant.
  - `mode`=1: grant the first channel with `in_valid` set, searching `ptr`, `ptr`+1, … and wrapping from CHANNELS-1 to 0.
- `in_ready[g] = load & grant_found`, one-hot on the granted channel, zero elsewhere.
- `in_ready` does not depend on `in_valid` of non-granted channels.
- Transfer on channel g (`in_valid[g] & in_ready[g]`):
  - `q` ← channel g data
  - `q_chan` ← g
  - `q_valid` ← 1
  - `ptr` ← g+1, wrapping to 0 when g = CHANNELS-1
- `ptr` updates in both modes, so switching to round-robin resumes after the last served channel.
- `load` with no grant: `q_valid` ← 0. `q` and `q_chan` hold their last values.
- FULL and `q_ready`=0: every output and `ptr` hold. All `in_ready` are 0.
- `mode` and `sel` are sampled every cycle with no latching. A change takes effect at the next arbitration.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): `q`=0, `q_valid`=0, `q_chan`=0, `ptr`=0.
- Combinational `in_ready` is also 0 during reset.
- Latency: 1 cycle from an input handshake to `q_valid`.
- Throughput: 1 item/cycle while `q_ready`=1. Back-to-back transfers need no bubble.
- Simultaneous drain and fill: `q_valid & q_ready` together with a grant replaces `q` in the same edge, and `q_valid` stays 1.
- Reset asserted mid-stream: a pending `q` is discarded and `ptr` returns to 0.
- Fairness: with all channels valid in `mode`=1, service order is ptr, ptr+1, … with no channel served twice before every valid channel is served once.
- Non-power-of-two CHANNELS: indices ≥ CHANNELS are never granted and never appear on `q_chan`.

## Structure
- Package `mux_pkg`:
  - mode constants `MODE_SEL`=1'b0 and `MODE_RR`=1'b1
  - index-width helper function
- Sub-module `rr_arbiter` (parameter CHANNELS):
  - inputs: request vector, `ptr`
  - outputs: one-hot grant, grant index, found flag
  - purely combinational, reusable elsewhere
- `mux_rr` holds the output register, `ptr`, and the mode mux between the `sel` decode and `rr_arbiter`.

## Test plan
Bench parameters: WIDTH=4, CHANNELS=4, unless stated.
- Reset: `rst_n`=0 with random inputs → `q`=0, `q_valid`=0, `q_chan`=0, `in_ready`=0000. After release with `in_valid`=0000, outputs stay at 0.
- Directed mode: `mode`=0, `sel`=2, `in`=16'hA5C3, `in_valid`=1111, `q_ready`=1 → `in_ready`=0100. Next cycle `q`=4'h5, `q_chan`=2, `q_valid`=1.
- Round-robin: `mode`=1, `in_valid`=1111 held, `in`=16'h4321, `q_ready`=1 → `q_chan` runs 0,1,2,3,0 and `q` runs 1,2,3,4,1 on consecutive cycles.
- Backpressure: FULL with `q`=4'h3, `q_ready`=0 for 3 cycles → `q`, `q_chan`, `q_valid` hold and `in_ready`=0000. With `q_ready`=1, the next granted item appears the following cycle with no loss or duplication.
- Sparse and wrap: `mode`=1, `ptr`=3, `in_valid`=0010 → grant channel 1 and `ptr` becomes 2. With `in_valid`=0000 and `q_ready`=1 → `q_valid` drops to 0 next cycle.
- Non-power-of-two: CHANNELS=3, `mode`=0, `sel`=3, all valid → `in_ready`=000 and `q_valid` stays 0. Switch to `mode`=1 → channels served 0,1,2,0.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared definitions for the mux_rr streaming merge stage.
//               Mode encodings, output-register state encoding and the
//               channel-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

   // Selection mode encodings for the mode input
   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Output register occupancy
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Width of an index able to address n items; never less than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority arbiter. Searches the request
//               vector starting at ptr, wrapping at CHANNELS-1, and returns a
//               one-hot grant, the granted index and a found flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int CHANNELS = 4,
   localparam int SELW     = idx_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   output logic [CHANNELS-1:0] gnt,
   output logic [SELW-1:0]     gnt_idx,
   output logic                found
);

   int idx;

   // Walk ptr, ptr+1, ... modulo CHANNELS and keep the first requester
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
         end
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = SELW'(idx);
            found    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr
// Description : N-channel streaming merge with valid/ready per channel, a
//               single registered output stage, and either sel-directed or
//               round-robin channel selection.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   localparam int SELW     = idx_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   input  logic [CHANNELS*WIDTH-1:0] in,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          q,
   output logic                      q_valid,
   output logic [SELW-1:0]           q_chan,
   input  logic                      q_ready
);

   localparam logic [SELW-1:0] C_LAST = SELW'(CHANNELS - 1);

   out_state_e          state_q, state_d;
   logic [WIDTH-1:0]    data_q,  data_d;
   logic [SELW-1:0]     chan_q,  chan_d;
   logic [SELW-1:0]     ptr_q,   ptr_d;

   logic [CHANNELS-1:0] w_sel_gnt;
   logic                w_sel_found;
   logic [CHANNELS-1:0] w_rr_gnt;
   logic [SELW-1:0]     w_rr_idx;
   logic                w_rr_found;

   logic [CHANNELS-1:0] w_gnt;
   logic [SELW-1:0]     w_gnt_idx;
   logic                w_gnt_found;
   logic                w_load;
   logic                w_xfer;

   // Directed decode: only an in-range sel with its channel valid is granted
   always_comb begin
      w_sel_gnt   = '0;
      w_sel_found = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if ((sel == SELW'(c)) && in_valid[c]) begin
            w_sel_gnt[c] = 1'b1;
            w_sel_found  = 1'b1;
         end
      end
   end

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_rr_arbiter (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt     (w_rr_gnt),
      .gnt_idx (w_rr_idx),
      .found   (w_rr_found)
   );

   // Pick the active grant source; the output stage accepts when empty or draining
   always_comb begin
      w_gnt       = (mode == MODE_RR) ? w_rr_gnt   : w_sel_gnt;
      w_gnt_idx   = (mode == MODE_RR) ? w_rr_idx   : sel;
      w_gnt_found = (mode == MODE_RR) ? w_rr_found : w_sel_found;
      w_load      = (state_q == ST_EMPTY) || q_ready;
      w_xfer      = w_load && w_gnt_found;
      in_ready    = (w_xfer && rst_n) ? w_gnt : '0;
   end

   // Next-state for the output register and the round-robin pointer
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      chan_d  = chan_q;
      ptr_d   = ptr_q;
      if (w_load) begin
         if (w_gnt_found) begin
            state_d = ST_FULL;
            chan_d  = w_gnt_idx;
            ptr_d   = (w_gnt_idx == C_LAST) ? '0 : (w_gnt_idx + SELW'(1));
            for (int c = 0; c < CHANNELS; c++) begin
               if (w_gnt[c]) begin
                  data_d = in[c*WIDTH +: WIDTH];
               end
            end
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // Output register and pointer; reset discards any pending item
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         chan_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         ptr_q   <= ptr_d;
      end
   end

   assign q       = data_q;
   assign q_valid = (state_q == ST_FULL);
   assign q_chan  = chan_q;

endmodule
`default_nettype wire
